lc3_decode: RTL and testbench

Registered decode stage of the LC3 pipeline: the RTL block that drives the `decode_out` interface. It captures the fetched instruction and its next-PC from the fetch stage. When enabled, it registers the instruction (`IR`), the next PC (`npc_out`) and the Execute, Writeback and Memory control words derived from the opcode. These registered outputs are what the `decode_out` agent samples on each rising clock edge while the decode enable is high.

---
 rtl/lc3_decode_pkg.sv | 51 +++++
 rtl/lc3_decode_ctrl_lut.sv | 77 +++++++
 rtl/lc3_decode.sv | 47 ++++
 tb/tb_lc3_decode.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/lc3_decode_pkg.sv
// Shared LC3 decode definitions: opcodes, E_Control field positions, writeback encodings.
// Imported by the decode RTL and by its testbench predictor.
package lc3_decode_pkg;

  typedef enum logic [3:0] {
    OP_BR   = 4'h0,
    OP_ADD  = 4'h1,
    OP_LD   = 4'h2,
    OP_ST   = 4'h3,
    OP_JSR  = 4'h4,
    OP_AND  = 4'h5,
    OP_LDR  = 4'h6,
    OP_STR  = 4'h7,
    OP_RTI  = 4'h8,
    OP_NOT  = 4'h9,
    OP_LDI  = 4'hA,
    OP_STI  = 4'hB,
    OP_JMP  = 4'hC,
    OP_RES  = 4'hD,
    OP_LEA  = 4'hE,
    OP_TRAP = 4'hF
  } opcode_t;

  // E_Control = {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}
  localparam int E_ALU_HI = 5;
  localparam int E_ALU_LO = 4;
  localparam int E_PC1_HI = 3;
  localparam int E_PC1_LO = 2;
  localparam int E_PC2    = 1;
  localparam int E_OP2    = 0;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_AND = 2'b01;
  localparam logic [1:0] ALU_NOT = 2'b10;

  localparam logic [1:0] PC1_NONE = 2'b00;
  localparam logic [1:0] PC1_OFF9 = 2'b01;
  localparam logic [1:0] PC1_OFF6 = 2'b10;
  localparam logic [1:0] PC1_ZERO = 2'b11;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;

  typedef struct packed {
    logic [5:0] e;
    logic [1:0] w;
    logic       m;
  } ctrl_t;

endpackage

// File: rtl/lc3_decode_ctrl_lut.sv
// Combinational map from {opcode, imm flag dout[5]} to the Execute/Writeback/Memory control words.
// No state; unsupported opcodes fall through to all-zero controls.
module lc3_decode_ctrl_lut
  import lc3_decode_pkg::*;
(
  input  logic [3:0] i_opcode,
  input  logic       i_imm_flag,
  output ctrl_t      o_ctrl
);

  logic [1:0] w_alu;
  logic [1:0] w_pc1;
  logic       w_pc2;
  logic       w_op2;
  logic [1:0] w_wb;
  logic       w_mem;

  always_comb begin
    w_alu = ALU_ADD;
    w_pc1 = PC1_NONE;
    w_pc2 = 1'b0;
    w_op2 = 1'b0;
    w_wb  = WB_ALU;
    w_mem = 1'b0;
    case (opcode_t'(i_opcode))
      OP_ADD: w_op2 = ~i_imm_flag;
      OP_AND: begin
        w_alu = ALU_AND;
        w_op2 = ~i_imm_flag;
      end
      OP_NOT: w_alu = ALU_NOT;
      OP_BR, OP_ST: begin
        w_pc1 = PC1_OFF9;
        w_pc2 = 1'b1;
      end
      OP_LD: begin
        w_pc1 = PC1_OFF9;
        w_pc2 = 1'b1;
        w_wb  = WB_MEM;
      end
      OP_LDI: begin
        w_pc1 = PC1_OFF9;
        w_pc2 = 1'b1;
        w_wb  = WB_MEM;
        w_mem = 1'b1;
      end
      OP_STI: begin
        w_pc1 = PC1_OFF9;
        w_pc2 = 1'b1;
        w_mem = 1'b1;
      end
      OP_LEA: begin
        w_pc1 = PC1_OFF9;
        w_pc2 = 1'b1;
        w_wb  = WB_PC;
      end
      OP_LDR: begin
        w_pc1 = PC1_OFF6;
        w_wb  = WB_MEM;
      end
      OP_STR: w_pc1 = PC1_OFF6;
      OP_JMP: w_pc1 = PC1_ZERO;
      default: ;
    endcase
  end

  always_comb begin
    o_ctrl = '0;
    o_ctrl.e[E_ALU_HI:E_ALU_LO] = w_alu;
    o_ctrl.e[E_PC1_HI:E_PC1_LO] = w_pc1;
    o_ctrl.e[E_PC2]             = w_pc2;
    o_ctrl.e[E_OP2]             = w_op2;
    o_ctrl.w                    = w_wb;
    o_ctrl.m                    = w_mem;
  end

endmodule

// File: rtl/lc3_decode.sv
// LC3 decode stage: registers IR, next PC and decoded controls one cycle after an enabled edge.
// enable_decode low holds every output; reset (sync, active-high) clears all and beats enable.
module lc3_decode
  import lc3_decode_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        enable_decode,
  input  logic [15:0] dout,
  input  logic [15:0] npc_in,
  output logic [15:0] IR,
  output logic [15:0] npc_out,
  output logic [5:0]  E_Control,
  output logic [1:0]  W_Control,
  output logic        Mem_Control
);

  ctrl_t       w_ctrl;
  logic [15:0] r_ir;
  logic [15:0] r_npc;
  ctrl_t       r_ctrl;

  lc3_decode_ctrl_lut u_ctrl_lut (
    .i_opcode   (dout[15:12]),
    .i_imm_flag (dout[5]),
    .o_ctrl     (w_ctrl)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ir   <= '0;
      r_npc  <= '0;
      r_ctrl <= '0;
    end else if (enable_decode) begin
      r_ir   <= dout;
      r_npc  <= npc_in;
      r_ctrl <= w_ctrl;
    end
  end

  assign IR          = r_ir;
  assign npc_out     = r_npc;
  assign E_Control   = r_ctrl.e;
  assign W_Control   = r_ctrl.w;
  assign Mem_Control = r_ctrl.m;

endmodule

// File: tb/tb_lc3_decode.sv
// Bench for lc3_decode: directed vectors with literal expectations, then random stimulus
// compared every cycle against an opcode-rule predictor.
module tb_lc3_decode;
  import lc3_decode_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable_decode;
  logic [15:0] dout;
  logic [15:0] npc_in;
  logic [15:0] IR;
  logic [15:0] npc_out;
  logic [5:0]  E_Control;
  logic [1:0]  W_Control;
  logic        Mem_Control;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  lc3_decode dut (
    .clock         (clock),
    .reset         (reset),
    .enable_decode (enable_decode),
    .dout          (dout),
    .npc_in        (npc_in),
    .IR            (IR),
    .npc_out       (npc_out),
    .E_Control     (E_Control),
    .W_Control     (W_Control),
    .Mem_Control   (Mem_Control)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Predictor: {E, W, M} from the opcode rules, E built arithmetically from its fields.
  function automatic logic [8:0] predict(input logic [15:0] instr);
    logic [3:0] op;
    int alu, pc1, pc2, op2, wb, mem, e;
    op  = instr[15:12];
    alu = (op == OP_AND) ? 1 : (op == OP_NOT) ? 2 : 0;
    pc2 = (op inside {OP_BR, OP_LD, OP_LDI, OP_LEA, OP_ST, OP_STI}) ? 1 : 0;
    pc1 = pc2 ? 1 : (op inside {OP_LDR, OP_STR}) ? 2 : (op == OP_JMP) ? 3 : 0;
    op2 = ((op inside {OP_ADD, OP_AND}) && !instr[5]) ? 1 : 0;
    wb  = (op inside {OP_LD, OP_LDR, OP_LDI}) ? 1 : (op == OP_LEA) ? 2 : 0;
    mem = (op inside {OP_LDI, OP_STI}) ? 1 : 0;
    e   = alu * 16 + pc1 * 4 + pc2 * 2 + op2;
    return {e[5:0], wb[1:0], mem[0]};
  endfunction

  logic [15:0] m_ir, m_npc;
  logic [5:0]  m_e;
  logic [1:0]  m_w;
  logic        m_m;
  bit          m_valid = 1'b0;

  always @(posedge clock) begin
    logic [8:0] p;
    if (reset === 1'b1) begin
      {m_ir, m_npc, m_e, m_w, m_m} = '0;
      m_valid = 1'b1;
    end else if (enable_decode === 1'b1) begin
      p = predict(dout);
      m_ir  = dout;
      m_npc = npc_in;
      {m_e, m_w, m_m} = p;
    end
    #1;
    if (m_valid) begin
      check("model_IR",  IR,               m_ir);
      check("model_npc", npc_out,          m_npc);
      check("model_E",   {10'd0, E_Control}, {10'd0, m_e});
      check("model_W",   {14'd0, W_Control}, {14'd0, m_w});
      check("model_M",   {15'd0, Mem_Control}, {15'd0, m_m});
    end
  end

  task automatic step(input logic r, input logic en, input logic [15:0] d, input logic [15:0] n);
    @(negedge clock);
    reset = r;
    enable_decode = en;
    dout = d;
    npc_in = n;
    @(posedge clock);
    #2;
  endtask

  task automatic check_lit(input string name, input logic [15:0] ir, input logic [15:0] npc,
                           input logic [5:0] e, input logic [1:0] w, input logic m);
    check({name, "_IR"},  IR,                  ir);
    check({name, "_npc"}, npc_out,             npc);
    check({name, "_E"},   {10'd0, E_Control},   {10'd0, e});
    check({name, "_W"},   {14'd0, W_Control},   {14'd0, w});
    check({name, "_M"},   {15'd0, Mem_Control}, {15'd0, m});
  endtask

  initial begin
    reset = 1'b1;
    enable_decode = 1'b1;
    dout = 16'hFFFF;
    npc_in = 16'h1234;

    step(1'b1, 1'b1, 16'hFFFF, 16'h1234);
    check_lit("reset", 16'h0000, 16'h0000, 6'h00, 2'b00, 1'b0);

    step(1'b0, 1'b1, 16'h12A3, 16'h3001);
    check_lit("add_imm", 16'h12A3, 16'h3001, 6'h00, 2'b00, 1'b0);
    step(1'b0, 1'b1, 16'h5705, 16'h3002);
    check_lit("and_reg", 16'h5705, 16'h3002, 6'h11, 2'b00, 1'b0);
    step(1'b0, 1'b1, 16'hA805, 16'h3003);
    check_lit("ldi", 16'hA805, 16'h3003, 6'h06, 2'b01, 1'b1);
    step(1'b0, 1'b1, 16'h7000, 16'h3004);
    check_lit("str", 16'h7000, 16'h3004, 6'h08, 2'b00, 1'b0);
    step(1'b0, 1'b1, 16'hE9FF, 16'h4000);
    check_lit("lea", 16'hE9FF, 16'h4000, 6'h06, 2'b10, 1'b0);
    step(1'b0, 1'b1, 16'hC0C0, 16'h4001);
    check_lit("jmp", 16'hC0C0, 16'h4001, 6'h0C, 2'b00, 1'b0);
    step(1'b0, 1'b1, 16'h9A3F, 16'h4002);
    check_lit("not", 16'h9A3F, 16'h4002, 6'h20, 2'b00, 1'b0);
    step(1'b0, 1'b1, 16'hB1FF, 16'h4003);
    check_lit("sti", 16'hB1FF, 16'h4003, 6'h06, 2'b00, 1'b1);

    step(1'b0, 1'b1, 16'h12A3, 16'h3001);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, (i % 2) ? 16'hA805 : 16'h5705, 16'h5000 + 16'(i));
      check_lit("hold", 16'h12A3, 16'h3001, 6'h00, 2'b00, 1'b0);
    end

    step(1'b0, 1'b1, 16'hA805, 16'h6000);
    step(1'b1, 1'b1, 16'h6FFF, 16'h6001);
    check_lit("mid_reset", 16'h0000, 16'h0000, 6'h00, 2'b00, 1'b0);
    step(1'b0, 1'b1, 16'hF025, 16'h6002);
    check_lit("trap", 16'hF025, 16'h6002, 6'h00, 2'b00, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 7),
           16'($urandom), 16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
